// File: rtl/lc3b_mem_arbiter.sv
// Serializes the LC-3b fetch port (A) and data port (B) onto one physical memory
// port with a hold-until-response handshake; round-robin on simultaneous requests.
module lc3b_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int BE_W   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_read,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_resp,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [BE_W-1:0]   b_byte_enable,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_resp,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [DATA_W-1:0] pmem_wdata,
  output logic [BE_W-1:0]   pmem_byte_enable,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              proto_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t state;
  logic   grant;
  logic   last_grant;
  logic   req_a;
  logic   req_b;
  logic   next_grant;

  // Grant B when it is the only requester, or on a conflict when A won last time.
  always_comb begin
    req_a      = a_read;
    req_b      = b_read | b_write;
    next_grant = req_b & (~req_a | ~last_grant);
  end

  // The pmem_* outputs double as the holding registers, so the captured request
  // is replayed unchanged for the whole ISSUE phase regardless of the live inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      grant            <= 1'b0;
      last_grant       <= 1'b0;
      pmem_addr        <= '0;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_wdata       <= '0;
      pmem_byte_enable <= '0;
      a_rdata          <= '0;
      b_rdata          <= '0;
      a_resp           <= 1'b0;
      b_resp           <= 1'b0;
      proto_err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_a || req_b) begin
            grant      <= next_grant;
            last_grant <= next_grant;
            state      <= ISSUE;
            if (next_grant) begin
              pmem_addr        <= b_addr;
              pmem_wdata       <= b_wdata;
              pmem_write       <= b_write;
              pmem_read        <= ~b_write;
              pmem_byte_enable <= b_write ? b_byte_enable : '1;
              if (b_read && b_write) begin
                proto_err <= 1'b1;
              end
            end else begin
              pmem_addr        <= a_addr;
              pmem_read        <= 1'b1;
              pmem_write       <= 1'b0;
              pmem_byte_enable <= '1;
            end
          end
        end
        ISSUE: begin
          if (pmem_resp) begin
            if (pmem_read) begin
              if (grant) begin
                b_rdata <= pmem_rdata;
              end else begin
                a_rdata <= pmem_rdata;
              end
            end
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            a_resp     <= ~grant;
            b_resp     <= grant;
            state      <= DONE;
          end
        end
        DONE: begin
          a_resp <= 1'b0;
          b_resp <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Directed self-checking bench for lc3b_mem_arbiter; the bench plays the physical
// memory by driving pmem_resp/pmem_rdata cycle by cycle.
module tb_lc3b_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] a_addr = '0;
  logic        a_read = 1'b0;
  logic [15:0] a_rdata;
  logic        a_resp;
  logic [15:0] b_addr = '0;
  logic        b_read = 1'b0;
  logic        b_write = 1'b0;
  logic [15:0] b_wdata = '0;
  logic [1:0]  b_byte_enable = '0;
  logic [15:0] b_rdata;
  logic        b_resp;
  logic [15:0] pmem_addr;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_rdata = '0;
  logic        pmem_resp = 1'b0;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  lc3b_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .a_addr(a_addr), .a_read(a_read), .a_rdata(a_rdata), .a_resp(a_resp),
    .b_addr(b_addr), .b_read(b_read), .b_write(b_write), .b_wdata(b_wdata),
    .b_byte_enable(b_byte_enable), .b_rdata(b_rdata), .b_resp(b_resp),
    .pmem_addr(pmem_addr), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Mutual-exclusion invariants watched on every falling edge while out of reset.
  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (a_resp && b_resp) begin
        errors++;
        $display("[TB] FAIL both_resp: a_resp=%b b_resp=%b required not both 1", a_resp, b_resp);
      end
      checks++;
      if (pmem_read && pmem_write) begin
        errors++;
        $display("[TB] FAIL both_strobes: pmem_read=%b pmem_write=%b required not both 1", pmem_read, pmem_write);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    a_read = 1'b0; b_read = 1'b0; b_write = 1'b0; pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pmem_addr, pmem_read, pmem_write, pmem_wdata, pmem_byte_enable} !== 36'd0) begin
      errors++;
      $display("[TB] FAIL reset_pmem: got addr=%h rd=%b wr=%b wd=%h be=%b required all 0",
               pmem_addr, pmem_read, pmem_write, pmem_wdata, pmem_byte_enable);
    end
    checks++;
    if ({a_resp, b_resp, a_rdata, b_rdata, proto_err} !== 35'd0) begin
      errors++;
      $display("[TB] FAIL reset_cpu: got a_resp=%b b_resp=%b a_rdata=%h b_rdata=%h perr=%b required all 0",
               a_resp, b_resp, a_rdata, b_rdata, proto_err);
    end
  endtask

  task automatic test_lone_fetch();
    a_addr = 16'h1000; a_read = 1'b1;
    step();
    checks++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_addr !== 16'h1000 || pmem_byte_enable !== 2'b11) begin
      errors++;
      $display("[TB] FAIL fetch_issue1: rd=%b wr=%b addr=%h be=%b required 1 0 1000 11",
               pmem_read, pmem_write, pmem_addr, pmem_byte_enable);
    end
    step();
    checks++;
    if (pmem_read !== 1'b1 || pmem_addr !== 16'h1000 || a_resp !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fetch_issue2: rd=%b addr=%h a_resp=%b required 1 1000 0", pmem_read, pmem_addr, a_resp);
    end
    pmem_resp = 1'b1; pmem_rdata = 16'h1234;
    step();
    pmem_resp = 1'b0; pmem_rdata = 16'h0000;
    checks++;
    if (a_resp !== 1'b1 || a_rdata !== 16'h1234 || b_resp !== 1'b0 || pmem_read !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fetch_done: a_resp=%b a_rdata=%h b_resp=%b rd=%b required 1 1234 0 0",
               a_resp, a_rdata, b_resp, pmem_read);
    end
    a_read = 1'b0;
    step();
    checks++;
    if (a_resp !== 1'b0 || a_rdata !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL fetch_after: a_resp=%b a_rdata=%h required 0 1234", a_resp, a_rdata);
    end
  endtask

  task automatic test_data_write();
    b_addr = 16'h2002; b_write = 1'b1; b_wdata = 16'hBEEF; b_byte_enable = 2'b10;
    step();
    checks++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_addr !== 16'h2002 ||
        pmem_wdata !== 16'hBEEF || pmem_byte_enable !== 2'b10) begin
      errors++;
      $display("[TB] FAIL write_issue: wr=%b rd=%b addr=%h wd=%h be=%b required 1 0 2002 beef 10",
               pmem_write, pmem_read, pmem_addr, pmem_wdata, pmem_byte_enable);
    end
    pmem_resp = 1'b1; pmem_rdata = 16'hDEAD;
    step();
    pmem_resp = 1'b0;
    checks++;
    if (b_resp !== 1'b1 || a_resp !== 1'b0 || b_rdata !== 16'h0000 || pmem_write !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_done: b_resp=%b a_resp=%b b_rdata=%h wr=%b required 1 0 0000 0",
               b_resp, a_resp, b_rdata, pmem_write);
    end
    b_write = 1'b0;
    step();
    checks++;
    if (b_resp !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_after: b_resp=%b required 0", b_resp);
    end
  endtask

  task automatic test_conflict();
    logic        exp_b;
    logic [15:0] rd;
    do_reset();
    a_addr = 16'h0A00; b_addr = 16'h0B00; a_read = 1'b1; b_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_b = (i % 2 == 0);
      rd = 16'hC000 + 16'(i);
      step();
      checks++;
      if (pmem_read !== 1'b1 || pmem_addr !== (exp_b ? 16'h0B00 : 16'h0A00)) begin
        errors++;
        $display("[TB] FAIL conflict_grant%0d: rd=%b addr=%h required 1 %h",
                 i, pmem_read, pmem_addr, exp_b ? 16'h0B00 : 16'h0A00);
      end
      step();
      pmem_resp = 1'b1; pmem_rdata = rd;
      step();
      pmem_resp = 1'b0;
      checks++;
      if (b_resp !== exp_b || a_resp !== ~exp_b || (exp_b ? b_rdata : a_rdata) !== rd) begin
        errors++;
        $display("[TB] FAIL conflict_resp%0d: a_resp=%b b_resp=%b a_rdata=%h b_rdata=%h required b_resp=%b data=%h",
                 i, a_resp, b_resp, a_rdata, b_rdata, exp_b, rd);
      end
      step();
    end
    a_read = 1'b0; b_read = 1'b0;
    step();
  endtask

  task automatic test_input_change();
    b_addr = 16'h3000; b_read = 1'b1;
    step();
    checks++;
    if (pmem_addr !== 16'h3000 || pmem_read !== 1'b1) begin
      errors++;
      $display("[TB] FAIL change_issue1: addr=%h rd=%b required 3000 1", pmem_addr, pmem_read);
    end
    b_addr = 16'h4000;
    step();
    checks++;
    if (pmem_addr !== 16'h3000) begin
      errors++;
      $display("[TB] FAIL change_issue2: addr=%h required 3000", pmem_addr);
    end
    pmem_resp = 1'b1; pmem_rdata = 16'h5555;
    step();
    pmem_resp = 1'b0;
    checks++;
    if (b_resp !== 1'b1 || b_rdata !== 16'h5555) begin
      errors++;
      $display("[TB] FAIL change_done: b_resp=%b b_rdata=%h required 1 5555", b_resp, b_rdata);
    end
    b_read = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_issue();
    a_addr = 16'h1111; a_read = 1'b1;
    step();
    checks++;
    if (pmem_read !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_issue: rd=%b required 1", pmem_read);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({pmem_addr, pmem_read, pmem_write, pmem_wdata, pmem_byte_enable, a_resp, b_resp,
         a_rdata, b_rdata, proto_err} !== 71'd0) begin
      errors++;
      $display("[TB] FAIL midrst_outputs: rd=%b addr=%h a_rdata=%h b_rdata=%h resp=%b%b required all 0",
               pmem_read, pmem_addr, a_rdata, b_rdata, a_resp, b_resp);
    end
    a_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    a_addr = 16'h0A0A; b_addr = 16'h0B0B; a_read = 1'b1; b_read = 1'b1;
    step();
    checks++;
    if (pmem_addr !== 16'h0B0B || pmem_read !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_first_grant: addr=%h rd=%b required 0b0b 1", pmem_addr, pmem_read);
    end
    a_read = 1'b0;
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    checks++;
    if (b_resp !== 1'b1 || a_resp !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_resp: a_resp=%b b_resp=%b required 0 1", a_resp, b_resp);
    end
    b_read = 1'b0;
    step();
  endtask

  task automatic test_proto_err();
    b_addr = 16'h0600; b_read = 1'b1; b_write = 1'b1; b_wdata = 16'h1357; b_byte_enable = 2'b01;
    step();
    checks++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_byte_enable !== 2'b01 || proto_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL perr_issue: wr=%b rd=%b be=%b perr=%b required 1 0 01 1",
               pmem_write, pmem_read, pmem_byte_enable, proto_err);
    end
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    b_read = 1'b0; b_write = 1'b0;
    step();
    a_addr = 16'h0700; a_read = 1'b1;
    step();
    pmem_resp = 1'b1; pmem_rdata = 16'h2468;
    step();
    pmem_resp = 1'b0;
    a_read = 1'b0;
    checks++;
    if (a_resp !== 1'b1 || a_rdata !== 16'h2468 || proto_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL perr_sticky: a_resp=%b a_rdata=%h perr=%b required 1 2468 1", a_resp, a_rdata, proto_err);
    end
    step();
    do_reset();
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL perr_cleared: perr=%b required 0", proto_err);
    end
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_data_write();
    test_conflict();
    test_input_change();
    test_reset_mid_issue();
    test_proto_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
